// File: rtl/bp_pkg.sv
// bp_pkg: sizes, request type, FSM states and weight arithmetic shared by the perceptron update path
package bp_pkg;
  localparam int H          = 10;
  localparam int IDX_W      = 10;
  localparam int W_WIDTH    = 8;
  localparam int Y_WIDTH    = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int SEL_W      = $clog2(H + 1);
  localparam int ROW_W      = (H + 1) * W_WIDTH;
  typedef enum logic [1:0] {IDLE, READ, DECIDE, WRITE} state_e;
  typedef struct packed {
    logic [IDX_W-1:0]          index;
    logic [H-1:0]              hist;
    logic signed [Y_WIDTH-1:0] y;
    logic                      taken;
  } bp_upd_t;
  // floor(1.93*h + 14) in integer arithmetic
  function automatic int theta_f(input int h);
    return (193 * h + 1400) / 100;
  endfunction
  localparam int THETA = theta_f(H);
  // w + d with d in {+1,-1} (2-bit two's complement), clamped to the signed weight range
  function automatic logic [W_WIDTH-1:0] sat_add(input logic [W_WIDTH-1:0] w, input logic [1:0] d);
    logic [W_WIDTH:0] s;
    s = {w[W_WIDTH-1], w} + {{(W_WIDTH-1){d[1]}}, d};
    return (s[W_WIDTH] != s[W_WIDTH-1]) ? {s[W_WIDTH], {(W_WIDTH-1){~s[W_WIDTH]}}} : s[W_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/perceptron_upd_fifo.sv
// perceptron_upd_fifo: update-request queue
//   clk, rst      clock, async active-low reset
//   push_i, din_i enqueue request (ignored when full or flushing)
//   pop_i         dequeue head (ignored when empty)
//   flush_i       empty the queue
//   dout_o        head entry; full_o / empty_o status
module perceptron_upd_fifo
  import bp_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  logic    pop_i,
  input  logic    flush_i,
  input  bp_upd_t din_i,
  output bp_upd_t dout_o,
  output logic    full_o,
  output logic    empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  bp_upd_t    mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  // pointers carry an extra wrap bit so full and empty are distinguishable
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  always_ff @(posedge clk)
    if (push_i && !full_o && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/perceptron_update_ctrl.sv
// perceptron_update_ctrl: queues resolved-branch updates, trains one weight row per request, keeps the committed GHR
//   clk, rst                         clock, async active-low reset
//   upd_valid/upd_ready              request handshake; upd_index/hist/y/taken request payload
//   flush                            drop queued, not yet started requests
//   tbl_rd_en/tbl_rd_index           row read, data on tbl_rd_data one cycle later
//   tbl_wr_en/index/sel/data         single-weight write port
//   ghr                              committed global history (bit 0 newest)
//   busy, upd_done                   FSM not idle; request retired pulse
module perceptron_update_ctrl
  import bp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [IDX_W-1:0]          upd_index,
  input  logic [H-1:0]              upd_hist,
  input  logic signed [Y_WIDTH-1:0] upd_y,
  input  logic                      upd_taken,
  input  logic                      flush,
  output logic                      tbl_rd_en,
  output logic [IDX_W-1:0]          tbl_rd_index,
  input  logic [ROW_W-1:0]          tbl_rd_data,
  output logic                      tbl_wr_en,
  output logic [IDX_W-1:0]          tbl_wr_index,
  output logic [SEL_W-1:0]          tbl_wr_sel,
  output logic [W_WIDTH-1:0]        tbl_wr_data,
  output logic [H-1:0]              ghr,
  output logic                      busy,
  output logic                      upd_done
);
  state_e              state_q, state_d;
  bp_upd_t             req, head, upd_q;
  logic [ROW_W-1:0]    row_q;
  logic [SEL_W-1:0]    k_q;
  logic [H-1:0]        ghr_q;
  logic                full, empty, accept, pop, train, last;
  logic [Y_WIDTH:0]    y_abs;
  logic [H:0]          x;
  logic [W_WIDTH-1:0]  w_cur;
  logic [1:0]          d;
  assign req       = '{index: upd_index, hist: upd_hist, y: upd_y, taken: upd_taken};
  assign upd_ready = !full;
  assign accept    = upd_valid && upd_ready;
  assign pop       = state_q == IDLE && !empty;
  assign ghr       = ghr_q;
  // one extra bit so that the most negative y has a representable magnitude
  assign y_abs = upd_q.y[Y_WIDTH-1] ? -{1'b1, upd_q.y} : {1'b0, upd_q.y};
  assign train = (!upd_q.y[Y_WIDTH-1] != upd_q.taken) || (y_abs <= (Y_WIDTH+1)'(THETA));
  assign last  = k_q == SEL_W'(H);
  // input vector with the bias input (always +1) at position 0
  assign x     = {upd_q.hist, 1'b1};
  assign w_cur = row_q[k_q*W_WIDTH +: W_WIDTH];
  assign d     = (upd_q.taken == x[k_q]) ? 2'b01 : 2'b11;
  perceptron_upd_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (req),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = empty ? IDLE : READ;
      READ:    state_d = DECIDE;
      DECIDE:  state_d = train ? WRITE : IDLE;
      default: state_d = last ? IDLE : WRITE;
    endcase
  end
  always_comb begin
    tbl_rd_en    = pop;
    tbl_rd_index = pop ? head.index : '0;
    tbl_wr_en    = state_q == WRITE;
    tbl_wr_index = tbl_wr_en ? upd_q.index : '0;
    tbl_wr_sel   = tbl_wr_en ? k_q : '0;
    tbl_wr_data  = tbl_wr_en ? sat_add(w_cur, d) : '0;
    busy         = state_q != IDLE;
    upd_done     = (state_q == DECIDE && !train) || (state_q == WRITE && last);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      upd_q <= '0;
      row_q <= '0;
      k_q   <= '0;
      ghr_q <= '0;
    end else begin
      if (accept) ghr_q <= {ghr_q[H-2:0], upd_taken};
      if (pop) upd_q <= head;
      if (state_q == READ) row_q <= tbl_rd_data;
      k_q <= (state_q == WRITE && !last) ? k_q + 1'b1 : '0;
    end
endmodule

// File: tb/tb_perceptron_update_ctrl.sv
// tb_perceptron_update_ctrl: directed scenarios against a behavioural weight table
module tb_perceptron_update_ctrl;
  logic        clk = 0, rst = 0;
  logic        upd_valid = 0, upd_ready, upd_taken = 0, flush = 0;
  logic [9:0]  upd_index = 0, upd_hist = 0;
  logic signed [11:0] upd_y = 0;
  logic        tbl_rd_en, tbl_wr_en, busy, upd_done;
  logic [9:0]  tbl_rd_index, tbl_wr_index, ghr;
  logic [3:0]  tbl_wr_sel;
  logic [7:0]  tbl_wr_data;
  logic [87:0] rd_data;
  logic [87:0] tbl [1024];
  logic        pre_en = 0;
  logic [9:0]  pre_idx = 0;
  logic [87:0] pre_row = 0;
  int tests = 0, failed = 0;
  int s_idx [8], s_hist [8], s_y [8], s_tk [8], ns;
  int wcyc [64], rcyc [16], dcyc [16], acyc [16], nw, nr, nd, na;
  logic [3:0] wsel [64];
  logic [7:0] wdata [64];
  logic [9:0] widx [64], ridx [16], ghr_c [64];
  logic rdy [64], busy_c [64];

  perceptron_update_ctrl dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_index(upd_index), .upd_hist(upd_hist), .upd_y(upd_y), .upd_taken(upd_taken),
    .flush(flush), .tbl_rd_en(tbl_rd_en), .tbl_rd_index(tbl_rd_index), .tbl_rd_data(rd_data),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_index(tbl_wr_index), .tbl_wr_sel(tbl_wr_sel),
    .tbl_wr_data(tbl_wr_data), .ghr(ghr), .busy(busy), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) tbl[pre_idx] <= pre_row;
    if (tbl_wr_en) tbl[tbl_wr_index][tbl_wr_sel*8 +: 8] <= tbl_wr_data;
    if (tbl_rd_en) rd_data <= tbl[tbl_rd_index];
  end

  task automatic preload(input int idx, input logic [87:0] row);
    @(negedge clk);
    pre_en = 1; pre_idx = 10'(idx); pre_row = row;
    @(negedge clk);
    pre_en = 0;
  endtask

  task automatic set_s(input int i, input int idx, input int hist, input int y, input int tk);
    s_idx[i] = idx; s_hist[i] = hist; s_y[i] = y; s_tk[i] = tk;
  endtask

  // cycle 0 is the cycle in which the first request is presented; a request is held until accepted
  task automatic run(input int n, input int fl_cyc);
    int si;
    logic acc;
    si = 0; nw = 0; nr = 0; nd = 0; na = 0; acc = 0;
    @(negedge clk);
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (acc) begin acyc[na] = c - 1; na++; si++; end
        if (tbl_rd_en) begin rcyc[nr] = c; ridx[nr] = tbl_rd_index; nr++; end
        if (tbl_wr_en) begin
          wcyc[nw] = c; wsel[nw] = tbl_wr_sel; wdata[nw] = tbl_wr_data; widx[nw] = tbl_wr_index; nw++;
        end
        if (upd_done) begin dcyc[nd] = c; nd++; end
        rdy[c] = upd_ready; ghr_c[c] = ghr; busy_c[c] = busy;
      end
      upd_valid = si < ns;
      if (si < ns) begin
        upd_index = 10'(s_idx[si]); upd_hist = 10'(s_hist[si]);
        upd_y = 12'(s_y[si]); upd_taken = s_tk[si][0];
      end
      flush = c == fl_cyc;
      acc = upd_valid && upd_ready && !flush;
    end
    upd_valid = 0; flush = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      tests++; if (upd_ready !== 1'b1) begin failed++; $display("FAIL reset_ready phase %0d: got %b exp 1", p, upd_ready); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy phase %0d: got %b exp 0", p, busy); end
      tests++; if ({tbl_rd_en, tbl_wr_en, upd_done} !== 3'b000) begin failed++; $display("FAIL reset_strobes phase %0d: got %b exp 000", p, {tbl_rd_en, tbl_wr_en, upd_done}); end
      tests++; if (ghr !== 10'd0) begin failed++; $display("FAIL reset_ghr phase %0d: got %h exp 0", p, ghr); end
      tests++; if ({tbl_rd_index, tbl_wr_index, tbl_wr_sel, tbl_wr_data} !== 32'd0) begin failed++; $display("FAIL reset_outs phase %0d: got %h exp 0", p, {tbl_rd_index, tbl_wr_index, tbl_wr_sel, tbl_wr_data}); end
      rst = 1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_mispredict();
    logic [7:0] e;
    preload(5, '0);
    ns = 1; set_s(0, 5, 1, -4, 1);
    run(16, -1);
    tests++; if (nr !== 1 || rcyc[0] !== 1 || ridx[0] !== 10'd5) begin failed++; $display("FAIL mis_read: got n=%0d cyc=%0d idx=%0d exp n=1 cyc=1 idx=5", nr, rcyc[0], ridx[0]); end
    tests++; if (nd !== 1 || dcyc[0] !== 14) begin failed++; $display("FAIL mis_done: got n=%0d cyc=%0d exp n=1 cyc=14", nd, dcyc[0]); end
    tests++; if (nw !== 11) begin failed++; $display("FAIL mis_nwrites: got %0d exp 11", nw); end
    for (int i = 0; i < 11; i++) begin
      e = (i <= 1) ? 8'h01 : 8'hFF;
      tests++;
      if (wsel[i] !== 4'(i) || wcyc[i] !== 4 + i || widx[i] !== 10'd5 || wdata[i] !== e) begin
        failed++; $display("FAIL mis_write%0d: got sel=%0d cyc=%0d idx=%0d data=%h exp sel=%0d cyc=%0d idx=5 data=%h", i, wsel[i], wcyc[i], widx[i], wdata[i], i, 4 + i, e);
      end
    end
    tests++; if (busy_c[14] !== 1'b1 || busy_c[15] !== 1'b0) begin failed++; $display("FAIL mis_idle: got busy14=%b busy15=%b exp 1 0", busy_c[14], busy_c[15]); end
  endtask

  task automatic test_train_decision();
    int ys [9] = '{50, 20, 33, 34, -34, -33, 0, -2048, 2047};
    int tk [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    int tr [9] = '{0, 1, 1, 0, 0, 1, 1, 0, 1};
    preload(7, '0);
    for (int i = 0; i < 9; i++) begin
      ns = 1; set_s(0, 7, 0, ys[i], tk[i]);
      run(16, -1);
      tests++; if (nd !== 1 || dcyc[0] !== (tr[i] != 0 ? 14 : 3)) begin failed++; $display("FAIL decide_done y=%0d t=%0d: got n=%0d cyc=%0d exp cyc=%0d", ys[i], tk[i], nd, dcyc[0], tr[i] != 0 ? 14 : 3); end
      tests++; if (nw !== (tr[i] != 0 ? 11 : 0)) begin failed++; $display("FAIL decide_writes y=%0d t=%0d: got %0d exp %0d", ys[i], tk[i], nw, tr[i] != 0 ? 11 : 0); end
    end
  endtask

  task automatic test_saturation();
    preload(9, {11{8'h7F}});
    preload(10, {11{8'h80}});
    ns = 1; set_s(0, 9, 10'h3FF, -1, 1);
    run(16, -1);
    tests++; if (nw !== 11) begin failed++; $display("FAIL sat_hi_nwrites: got %0d exp 11", nw); end
    for (int i = 0; i < 11; i++) begin
      tests++; if (wdata[i] !== 8'h7F) begin failed++; $display("FAIL sat_hi%0d: got %h exp 7f", i, wdata[i]); end
    end
    ns = 1; set_s(0, 10, 10'h3FF, 5, 0);
    run(16, -1);
    tests++; if (nw !== 11) begin failed++; $display("FAIL sat_lo_nwrites: got %0d exp 11", nw); end
    for (int i = 0; i < 11; i++) begin
      tests++; if (wdata[i] !== 8'h80) begin failed++; $display("FAIL sat_lo%0d: got %h exp 80", i, wdata[i]); end
    end
  endtask

  task automatic test_reset_mid_write();
    preload(12, '0);
    ns = 1; set_s(0, 12, 1, -4, 1);
    run(6, -1);
    tests++; if (tbl_wr_en !== 1'b1 || ghr[0] !== 1'b1) begin failed++; $display("FAIL rstw_pre: got wr_en=%b ghr0=%b exp 1 1", tbl_wr_en, ghr[0]); end
    rst = 0;
    @(negedge clk);
    tests++; if (busy !== 1'b0 || tbl_wr_en !== 1'b0 || upd_done !== 1'b0) begin failed++; $display("FAIL rstw_idle: got busy=%b wr=%b done=%b exp 0 0 0", busy, tbl_wr_en, upd_done); end
    tests++; if (ghr !== 10'd0) begin failed++; $display("FAIL rstw_ghr: got %h exp 0", ghr); end
    rst = 1;
    @(negedge clk);
    tests++; if (busy !== 1'b0 || tbl_rd_en !== 1'b0 || upd_ready !== 1'b1) begin failed++; $display("FAIL rstw_after: got busy=%b rd=%b rdy=%b exp 0 0 1", busy, tbl_rd_en, upd_ready); end
  endtask

  task automatic test_back_to_back();
    preload(3, '0);
    ns = 6;
    set_s(0, 3, 1, -4, 1);
    set_s(1, 3, 0, 100, 1);
    set_s(2, 3, 0, -100, 0);
    set_s(3, 3, 0, 100, 1);
    set_s(4, 3, 0, -100, 0);
    set_s(5, 3, 0, 100, 1);
    run(32, -1);
    tests++; if (rdy[4] !== 1'b1 || rdy[5] !== 1'b0 || rdy[15] !== 1'b0 || rdy[16] !== 1'b1) begin failed++; $display("FAIL b2b_ready: got c4=%b c5=%b c15=%b c16=%b exp 1 0 0 1", rdy[4], rdy[5], rdy[15], rdy[16]); end
    tests++; if (na !== 6 || acyc[5] !== 16) begin failed++; $display("FAIL b2b_accept: got n=%0d last=%0d exp n=6 last=16", na, acyc[5]); end
    tests++; if (ghr_c[4] !== 10'b0000001101) begin failed++; $display("FAIL b2b_ghr4: got %b exp 0000001101", ghr_c[4]); end
    tests++; if (ghr_c[17] !== 10'b0000110101) begin failed++; $display("FAIL b2b_ghr_final: got %b exp 0000110101", ghr_c[17]); end
    tests++; if (nd !== 6 || dcyc[0] !== 14 || dcyc[1] !== 17 || dcyc[5] !== 29) begin failed++; $display("FAIL b2b_done: got n=%0d %0d %0d %0d exp n=6 14 17 29", nd, dcyc[0], dcyc[1], dcyc[5]); end
    tests++; if (nr !== 6 || rcyc[1] !== 15 || rcyc[5] !== 27) begin failed++; $display("FAIL b2b_reads: got n=%0d %0d %0d exp n=6 15 27", nr, rcyc[1], rcyc[5]); end
    tests++; if (nw !== 11 || busy_c[29] !== 1'b1 || busy_c[30] !== 1'b0) begin failed++; $display("FAIL b2b_tail: got nw=%0d busy29=%b busy30=%b exp 11 1 0", nw, busy_c[29], busy_c[30]); end
  endtask

  task automatic test_same_index();
    preload(4, '0);
    ns = 2;
    set_s(0, 4, 1, -4, 1);
    set_s(1, 4, 1, 0, 1);
    run(30, -1);
    tests++; if (nr !== 2 || rcyc[1] !== 15) begin failed++; $display("FAIL same_read2: got n=%0d cyc=%0d exp n=2 cyc=15", nr, rcyc[1]); end
    tests++; if (nw !== 22 || wcyc[11] !== 18) begin failed++; $display("FAIL same_nwrites: got n=%0d first2=%0d exp 22 18", nw, wcyc[11]); end
    tests++; if (wdata[11] !== 8'h02 || wdata[12] !== 8'h02 || wdata[21] !== 8'hFE) begin failed++; $display("FAIL same_data: got %h %h %h exp 02 02 fe", wdata[11], wdata[12], wdata[21]); end
    tests++; if (nd !== 2 || dcyc[1] !== 28) begin failed++; $display("FAIL same_done: got n=%0d cyc=%0d exp 2 28", nd, dcyc[1]); end
  endtask

  task automatic test_flush();
    preload(11, '0);
    ns = 5;
    set_s(0, 11, 1, -4, 1);
    for (int i = 1; i < 5; i++) set_s(i, 11, 0, 100, 1);
    run(20, 6);
    tests++; if (rdy[6] !== 1'b0 || rdy[7] !== 1'b1) begin failed++; $display("FAIL flush_ready: got c6=%b c7=%b exp 0 1", rdy[6], rdy[7]); end
    tests++; if (nr !== 1) begin failed++; $display("FAIL flush_reads: got %0d exp 1", nr); end
    tests++; if (nw !== 11 || nd !== 1 || dcyc[0] !== 14) begin failed++; $display("FAIL flush_first: got nw=%0d nd=%0d done=%0d exp 11 1 14", nw, nd, dcyc[0]); end
    tests++; if (busy_c[16] !== 1'b0 || busy_c[20] !== 1'b0) begin failed++; $display("FAIL flush_idle: got busy16=%b busy20=%b exp 0 0", busy_c[16], busy_c[20]); end
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_train_decision();
    test_saturation();
    test_reset_mid_write();
    test_back_to_back();
    test_same_index();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
